// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and constants for the serial sample loader:
//               loader state encoding, sample geometry and lane word type.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Loader control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        PREPARE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Bytes per sample: input word, expected-output word, valid-mask word
    localparam int SAMPLE_BYTES = 12;

    // Lanes per word
    localparam int LANES = 4;

    // Byte counter value of the final byte of a sample
    localparam logic [3:0] LAST_BYTE = 4'(SAMPLE_BYTES - 1);

    // One word of LANES byte lanes; lane [0] is the first byte streamed
    typedef logic [LANES-1:0][7:0] word_t;

endpackage
`default_nettype wire

// File: rtl/sample_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : sample_byte_assembler
// Description : Byte counter plus three lane registers. Each accepted byte
//               lands in lane (count mod 4) of word (count div 4); a pulse
//               marks the cycle the last byte of a sample is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_byte_assembler
    import serial_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_accept,
    input  logic [7:0]      i_byte,
    output logic [3:0][7:0] o_input_word,
    output logic [3:0][7:0] o_expected_word,
    output logic [3:0][7:0] o_valid_word,
    output logic            o_sample_done
);

    logic [3:0] count_q;
    logic [3:0] count_d;
    word_t      input_q;
    word_t      input_d;
    word_t      expected_q;
    word_t      expected_d;
    word_t      valid_q;
    word_t      valid_d;

    // Route an accepted byte into its lane and advance the byte counter;
    // the counter wraps to zero on the last byte so the next sample starts clean.
    // Clearing touches only the counter: the words stay stable until overwritten.
    always_comb begin
        count_d       = count_q;
        input_d       = input_q;
        expected_d    = expected_q;
        valid_d       = valid_q;
        o_sample_done = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_accept) begin
            case (count_q[3:2])
                2'd0:    input_d[count_q[1:0]]    = i_byte;
                2'd1:    expected_d[count_q[1:0]] = i_byte;
                default: valid_d[count_q[1:0]]    = i_byte;
            endcase
            if (count_q == LAST_BYTE) begin
                count_d       = '0;
                o_sample_done = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // Counter and lane registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            input_q    <= '0;
            expected_q <= '0;
            valid_q    <= '0;
        end else begin
            count_q    <= count_d;
            input_q    <= input_d;
            expected_q <= expected_d;
            valid_q    <= valid_d;
        end
    end

    assign o_input_word    = input_q;
    assign o_expected_word = expected_q;
    assign o_valid_word    = valid_q;

endmodule
`default_nettype wire

// File: rtl/serial_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_sample_loader
// Description : Streams NUM_SAMPLES+1 twelve-byte samples into the sample
//               store through its prepare/write handshake, assigning indices
//               in ascending order and flagging completion.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sample_loader
    import serial_pkg::*;
#(
    parameter int NUM_SAMPLES = 8
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iStart,
    input  logic [7:0]      iByte,
    input  logic            iByteValid,
    output logic            oByteReady,
    input  logic            iNextSample,
    output logic            oPreparingNextSample,
    output logic            oWriteSample,
    output logic [3:0][7:0] oCurrentSerialInput,
    output logic [3:0][7:0] oCurrentSerialExpectedOutput,
    output logic [3:0][7:0] oCurrentSerialValidOutput,
    output logic [31:0]     oSampleIndex,
    output logic            oBusy,
    output logic            oDone
);

    localparam logic [31:0] LAST_INDEX = 32'(NUM_SAMPLES);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] index_q;
    logic [31:0] index_d;
    logic        clear;
    logic        accept;
    logic        sample_done;

    // Bytes are consumed only while collecting; valid elsewhere is ignored
    assign accept = iByteValid && (state_q == COLLECT);

    sample_byte_assembler u_assembler (
        .clk             (iClock),
        .rst             (iReset),
        .i_clear         (clear),
        .i_accept        (accept),
        .i_byte          (iByte),
        .o_input_word    (oCurrentSerialInput),
        .o_expected_word (oCurrentSerialExpectedOutput),
        .o_valid_word    (oCurrentSerialValidOutput),
        .o_sample_done   (sample_done)
    );

    // Next-state, index and counter-clear decisions for the load sequence
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d = COLLECT;
                    index_d = '0;
                    clear   = 1'b1;
                end
            end
            COLLECT: begin
                if (sample_done) begin
                    state_d = PREPARE;
                end
            end
            PREPARE: begin
                if (iNextSample) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (index_q == LAST_INDEX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 32'd1;
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and sample index registers
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Prepare mirrors the store's readiness so it is never raised while the store is busy
    assign oByteReady           = (state_q == COLLECT);
    assign oPreparingNextSample = (state_q == PREPARE) && iNextSample;
    assign oWriteSample         = (state_q == WRITE);
    assign oSampleIndex         = index_q;
    assign oBusy                = (state_q != IDLE) && (state_q != DONE);
    assign oDone                = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sample_loader
// Description : Self-checking bench for serial_sample_loader. Two instances
//               (NUM_SAMPLES = 0 and 3) share one stimulus stream; results
//               are compared against a flat byte-position model of a sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sample_loader;
    import serial_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic        next_sample = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic            r3, p3, w3, b3, d3;
    logic [3:0][7:0] in3, ex3, vm3;
    logic [31:0]     idx3;
    logic            r0, p0, w0, b0, d0;
    logic [3:0][7:0] in0, ex0, vm0;
    logic [31:0]     idx0;

    int errors = 0;
    int checks = 0;
    logic [63:0] cyc = 64'd0;

    typedef struct packed {
        logic [31:0] idx;
        logic [95:0] data;
        logic [63:0] cyc;
    } wr_t;

    wr_t         wr3_q[$];
    wr_t         wr0_q[$];
    logic [7:0]  q_bytes[$];
    logic        prep_last = 1'b0;

    serial_sample_loader #(.NUM_SAMPLES(3)) dut3 (
        .iClock(clk), .iReset(rst), .iStart(start), .iByte(byte_in),
        .iByteValid(byte_valid), .oByteReady(r3), .iNextSample(next_sample),
        .oPreparingNextSample(p3), .oWriteSample(w3),
        .oCurrentSerialInput(in3), .oCurrentSerialExpectedOutput(ex3),
        .oCurrentSerialValidOutput(vm3), .oSampleIndex(idx3),
        .oBusy(b3), .oDone(d3)
    );

    serial_sample_loader #(.NUM_SAMPLES(0)) dut0 (
        .iClock(clk), .iReset(rst), .iStart(start), .iByte(byte_in),
        .iByteValid(byte_valid), .oByteReady(r0), .iNextSample(next_sample),
        .oPreparingNextSample(p0), .oWriteSample(w0),
        .oCurrentSerialInput(in0), .oCurrentSerialExpectedOutput(ex0),
        .oCurrentSerialValidOutput(vm0), .oSampleIndex(idx0),
        .oBusy(b0), .oDone(d0)
    );

    always #5 clk = ~clk;

    // Cycle number of the current clock period
    always @(posedge clk) cyc <= cyc + 64'd1;

    // Record every write strobe with the data the store would latch
    always @(negedge clk) begin
        if (w3) wr3_q.push_back({idx3, vm3, ex3, in3, cyc});
        if (w0) wr0_q.push_back({idx0, vm0, ex0, in0, cyc});
    end

    // Handshake rules: no prepare without store readiness, write only after a prepare
    always @(posedge clk) begin
        if (p3 || w3) begin
            checks++;
            if (p3 && !next_sample) begin
                errors++;
                $display("FAIL handshake_prep_without_next: prep=%0b next=%0b", p3, next_sample);
            end else if (w3 && !prep_last) begin
                errors++;
                $display("FAIL handshake_write_without_prep: write=%0b prev_prep=%0b", w3, prep_last);
            end
        end
        prep_last <= p3;
    end

    // Model: byte k of a sample sits at bit offset 8*k of {mask, expected, input}
    task automatic load_sample(input bit fixed, output logic [95:0] exp);
        exp = '0;
        for (int k = 0; k < SAMPLE_BYTES; k++) begin
            logic [7:0] b;
            b = fixed ? 8'(k + 1) : 8'($urandom_range(0, 255));
            exp[8*k +: 8] = b;
            q_bytes.push_back(b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; next_sample = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr3_q.delete(); wr0_q.delete(); q_bytes.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present the head of the byte queue; it is consumed at the coming edge when ready
    task automatic stream_step(input bit allow);
        if (allow && q_bytes.size() > 0) begin
            byte_valid = 1'b1;
            byte_in    = q_bytes[0];
            if (r3) void'(q_bytes.pop_front());
        end else begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({r3, p3, w3, b3, d3} !== 5'b0) begin errors++; $display("FAIL reset_flags3: got %b want 00000", {r3, p3, w3, b3, d3}); end
        checks++;
        if ({vm3, ex3, in3, idx3} !== 128'b0) begin errors++; $display("FAIL reset_data3: got %h want 0", {vm3, ex3, in3, idx3}); end
        checks++;
        if ({r0, p0, w0, b0, d0, vm0, ex0, in0, idx0} !== 133'b0) begin errors++; $display("FAIL reset_all0: got %h want 0", {r0, p0, w0, b0, d0, vm0, ex0, in0, idx0}); end
        for (int i = 0; i < 20; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom_range(1, 255));
            @(negedge clk);
            checks++;
            if ({r3, b3, r0, b0} !== 4'b0) begin errors++; $display("FAIL idle_ready_busy: got %b want 0000", {r3, b3, r0, b0}); end
        end
        byte_valid = 1'b0;
        checks++;
        if ({vm3, ex3, in3} !== 96'b0) begin errors++; $display("FAIL idle_no_consume: got %h want 0", {vm3, ex3, in3}); end
    endtask

    task automatic test_single_sample();
        logic [95:0] exp;
        bit          done_seen = 1'b0;
        do_reset();
        next_sample = 1'b1;
        load_sample(1'b1, exp);
        pulse_start();
        checks++;
        if (r0 !== 1'b1) begin errors++; $display("FAIL start_to_ready: got %b want 1", r0); end
        for (int i = 0; i < 60 && !done_seen; i++) begin
            stream_step(1'b1);
            @(negedge clk);
            done_seen = d0;
        end
        byte_valid = 1'b0;
        checks++;
        if (!done_seen) begin errors++; $display("FAIL single_done_timeout: got done=0 want 1"); end
        checks++;
        if (wr0_q.size() !== 1) begin
            errors++; $display("FAIL single_write_count: got %0d want 1", wr0_q.size());
        end else begin
            checks++;
            if (wr0_q[0].idx !== 32'd0) begin errors++; $display("FAIL single_index: got %0d want 0", wr0_q[0].idx); end
            checks++;
            if (wr0_q[0].data !== exp) begin errors++; $display("FAIL single_data: got %h want %h", wr0_q[0].data, exp); end
            checks++;
            if (wr0_q[0].data[31:0] !== 32'h04030201) begin errors++; $display("FAIL single_input_word: got %h want 04030201", wr0_q[0].data[31:0]); end
        end
        checks++;
        if ({d0, b0} !== 2'b10) begin errors++; $display("FAIL single_done_state: got done,busy=%b want 10", {d0, b0}); end
    endtask

    task automatic test_full_table();
        logic [95:0] exp[4];
        logic [63:0] start_cyc;
        logic [63:0] done_cyc = '0;
        bit          done_seen = 1'b0;
        do_reset();
        next_sample = 1'b1;
        for (int k = 0; k < 4; k++) load_sample(1'b0, exp[k]);
        start_cyc = cyc;
        pulse_start();
        for (int i = 0; i < 300 && !done_seen; i++) begin
            stream_step(1'b1);
            @(negedge clk);
            if (d3) begin done_seen = 1'b1; done_cyc = cyc; end
        end
        byte_valid = 1'b0;
        checks++;
        if (!done_seen || wr3_q.size() !== 4) begin
            errors++; $display("FAIL full_write_count: got %0d done=%0b want 4 done=1", wr3_q.size(), done_seen);
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [63:0] gap;
                gap = (k == 0) ? wr3_q[0].cyc - start_cyc : wr3_q[k].cyc - wr3_q[k-1].cyc;
                checks++;
                if (wr3_q[k].idx !== 32'(k)) begin errors++; $display("FAIL full_index%0d: got %0d want %0d", k, wr3_q[k].idx, k); end
                checks++;
                if (wr3_q[k].data !== exp[k]) begin errors++; $display("FAIL full_data%0d: got %h want %h", k, wr3_q[k].data, exp[k]); end
                checks++;
                if (gap !== 64'd14) begin errors++; $display("FAIL full_spacing%0d: got %0d want 14", k, gap); end
            end
            checks++;
            if (done_cyc !== wr3_q[3].cyc + 64'd1) begin errors++; $display("FAIL full_done_timing: got %0d want %0d", done_cyc, wr3_q[3].cyc + 64'd1); end
        end
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({d3, b3, r3, idx3} !== {3'b100, 32'd3}) begin errors++; $display("FAIL done_hold: got done,busy,ready=%b idx=%0d want 100 idx=3", {d3, b3, r3}, idx3); end
        end
        byte_valid = 1'b0;
        pulse_start();
        checks++;
        if ({d3, r3, idx3} !== {2'b01, 32'd0}) begin errors++; $display("FAIL restart_from_done: got done,ready=%b idx=%0d want 01 idx=0", {d3, r3}, idx3); end
    endtask

    task automatic test_store_stall();
        logic [95:0] exp;
        bit          in_prep = 1'b0;
        do_reset();
        next_sample = 1'b0;
        load_sample(1'b0, exp);
        pulse_start();
        for (int i = 0; i < 40 && !in_prep; i++) begin
            stream_step(1'b1);
            @(negedge clk);
            in_prep = (q_bytes.size() == 0) && !r3 && b3;
        end
        checks++;
        if (!in_prep) begin errors++; $display("FAIL stall_reach_prepare: got 0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom_range(0, 255));
            @(negedge clk);
            checks++;
            if ({p3, w3, vm3, ex3, in3, idx3} !== {2'b00, exp, 32'd0}) begin
                errors++; $display("FAIL stall_hold: got prep,write=%b data=%h idx=%0d want 00 %h 0", {p3, w3}, {vm3, ex3, in3}, idx3, exp);
            end
        end
        byte_valid  = 1'b0;
        next_sample = 1'b1;
        #1;
        checks++;
        if (p3 !== 1'b1) begin errors++; $display("FAIL stall_release_prep: got %b want 1", p3); end
        @(negedge clk);
        checks++;
        if ({w3, vm3, ex3, in3, idx3} !== {1'b1, exp, 32'd0}) begin
            errors++; $display("FAIL stall_write: got write=%b data=%h idx=%0d want 1 %h 0", w3, {vm3, ex3, in3}, idx3, exp);
        end
        @(negedge clk);
        checks++;
        if ({w3, r3, idx3} !== {2'b01, 32'd1}) begin errors++; $display("FAIL stall_after_write: got write,ready=%b idx=%0d want 01 idx=1", {w3, r3}, idx3); end
    endtask

    task automatic test_byte_gaps();
        logic [95:0] exp;
        do_reset();
        next_sample = 1'b1;
        load_sample(1'b0, exp);
        pulse_start();
        for (int i = 0; i < 60 && wr3_q.size() == 0; i++) begin
            stream_step(i % 2 == 0);
            if (q_bytes.size() > 0) begin
                checks++;
                if (r3 !== 1'b1) begin errors++; $display("FAIL gaps_ready: got %b want 1", r3); end
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        checks++;
        if (wr3_q.size() !== 1) begin
            errors++; $display("FAIL gaps_write_count: got %0d want 1", wr3_q.size());
        end else begin
            checks++;
            if ({wr3_q[0].idx, wr3_q[0].data} !== {32'd0, exp}) begin
                errors++; $display("FAIL gaps_data: got idx=%0d %h want idx=0 %h", wr3_q[0].idx, wr3_q[0].data, exp);
            end
        end
    endtask

    task automatic test_reset_mid_sample();
        logic [95:0] exp;
        logic [95:0] junk;
        do_reset();
        next_sample = 1'b1;
        load_sample(1'b0, exp);
        pulse_start();
        for (int i = 0; i < 60 && wr3_q.size() == 0; i++) begin
            stream_step(1'b1);
            start = (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (wr3_q.size() !== 1 || {wr3_q[0].idx, wr3_q[0].data} !== {32'd0, exp}) begin
            errors++; $display("FAIL start_ignored_busy: got writes=%0d want 1 write idx=0 data=%h", wr3_q.size(), exp);
        end
        // Seven bytes of the next sample, then reset mid-sample
        load_sample(1'b0, junk);
        while (q_bytes.size() > 5) begin
            stream_step(1'b1);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        q_bytes.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({r3, b3, d3, vm3, ex3, in3, idx3} !== 131'b0) begin
            errors++; $display("FAIL mid_reset_state: got ready,busy,done=%b data=%h idx=%0d want 0", {r3, b3, d3}, {vm3, ex3, in3}, idx3);
        end
        wr3_q.delete();
        load_sample(1'b0, exp);
        pulse_start();
        for (int i = 0; i < 60 && wr3_q.size() == 0; i++) begin
            stream_step(1'b1);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        checks++;
        if (wr3_q.size() !== 1) begin
            errors++; $display("FAIL mid_reset_write_count: got %0d want 1", wr3_q.size());
        end else begin
            checks++;
            if ({wr3_q[0].idx, wr3_q[0].data} !== {32'd0, exp}) begin
                errors++; $display("FAIL mid_reset_fresh: got idx=%0d %h want idx=0 %h", wr3_q[0].idx, wr3_q[0].data, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_full_table();
        test_store_stall();
        test_byte_gaps();
        test_reset_mid_sample();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_sample_loader.md
# serial_sample_loader

Upstream feeder for the serial sample store. Accepts a byte stream of test samples (serial input, expected output, valid-output mask), assembles each sample into three 4-lane × 8-bit words, then delivers them to the sample store through its prepare/write handshake. Sample indices are assigned in ascending order, and the block flags completion once the full table has been written.

## Interface
Parameters:
- NUM_SAMPLES, 8, highest sample index; the block loads NUM_SAMPLES+1 samples (indices 0..NUM_SAMPLES), matching the store depth.

Ports:
- iClock  input  1  single clock; all logic on posedge
- iReset  input  1  synchronous, active-high reset
- iStart  input  1  begins a load of the full table; honoured only in IDLE or DONE
- iByte  input  8  stream byte
- iByteValid  input  1  iByte is valid
- oByteReady  output  1  block accepts a byte this cycle
- iNextSample  input  1  sample store is idle and can take a sample
- oPreparingNextSample  output  1  announces a sample to the store
- oWriteSample  output  1  one-cycle write strobe to the store
- oCurrentSerialInput  output  [3:0][7:0]  assembled input word
- oCurrentSerialExpectedOutput  output  [3:0][7:0]  assembled expected-output word
- oCurrentSerialValidOutput  output  [3:0][7:0]  assembled valid mask
- oSampleIndex  output  32  index of the sample being delivered
- oBusy  output  1  state is neither IDLE nor DONE
- oDone  output  1  all NUM_SAMPLES+1 samples written; held until iStart or reset

## Operation
- Sample format: 12 bytes in stream order.
  - Bytes 0-3: input lanes [0]..[3].
  - Bytes 4-7: expected-output lanes [0]..[3].
  - Bytes 8-11: valid-mask lanes [0]..[3].
- A byte is accepted when iByteValid && oByteReady at a posedge. oByteReady = (state == COLLECT).
- Byte counter is 4 bits, 0..11. Each accepted byte is written to lane (count mod 4) of word (count div 4).
- States:
  - IDLE: on iStart, clear index and byte counter, go to COLLECT.
  - COLLECT: accept bytes. The cycle the 12th byte is accepted, go to PREPARE and clear the byte counter.
  - PREPARE: oPreparingNextSample = iNextSample (combinational, gated by state). When iNextSample = 1, go to WRITE. Otherwise wait indefinitely.
  - WRITE: oWriteSample = 1 for exactly one cycle.
    - If index == NUM_SAMPLES, go to DONE and keep the index.
    - Otherwise increment the index and go to COLLECT.
  - DONE: oDone = 1. iStart restarts as from IDLE, and clears oDone on the same edge.
- The three data words and oSampleIndex are held stable from the final byte acceptance through the WRITE cycle. They change only on byte acceptance, index increment, or reset.
- iStart is ignored while oBusy = 1.
- iByteValid outside COLLECT is ignored; no byte is consumed.
- Reset mid-operation: return to IDLE and discard the partial sample. Samples already written to the store are not retracted.

## Timing
- Reset values: state IDLE, all data words 0, oSampleIndex 0, oByteReady 0, oPreparingNextSample 0, oWriteSample 0, oBusy 0, oDone 0.
- iStart at edge t → oByteReady = 1 in cycle t+1.
- 12th byte accepted at edge t → PREPARE in cycle t+1.
- If iNextSample = 1 in cycle t+1: oPreparingNextSample = 1 in t+1, oWriteSample = 1 in t+2, store latches at edge ending t+2. This matches the store's one-cycle IDLE→WAITING step.
- Next COLLECT begins in t+3.
- Minimum per sample with no stalls: 12 byte cycles + 2 handshake cycles = 14 cycles.
- oPreparingNextSample is never asserted while iNextSample = 0.
- oWriteSample always follows an accepted prepare by exactly one cycle.

## Structure
- Shared package `serial_pkg`:
  - state enum {IDLE, COLLECT, PREPARE, WRITE, DONE}
  - SAMPLE_BYTES = 12
  - LANES = 4
  - the [3:0][7:0] word typedef
- One natural sub-module, `sample_byte_assembler`: byte counter plus the three lane registers. It raises a sample-complete pulse and takes a clear input. The FSM, index counter and handshake logic stay in the top module.

## Test plan
- Reset then idle: after iReset, all outputs are 0. With iStart = 0 and iByteValid = 1 for 20 cycles, no byte is accepted and oBusy stays 0.
- Single sample, NUM_SAMPLES = 0: stream bytes 0x01..0x0C with iNextSample = 1.
  - Input word = {0x04,0x03,0x02,0x01} (lane [0] = 0x01), expected = {0x08..0x05}, mask = {0x0C..0x09}.
  - oWriteSample pulses once with index 0, then oDone = 1.
- Full table, NUM_SAMPLES = 3: back-to-back stream of 48 bytes.
  - Writes occur at indices 0, 1, 2, 3, 14 cycles apart.
  - oDone rises the cycle after the 4th write.
- Store stall: hold iNextSample = 0 for 10 cycles in PREPARE.
  - oPreparingNextSample stays 0 and data stays stable.
  - Release → prepare pulse, then write one cycle later.
- Byte gaps: deassert iByteValid on alternate cycles. The sample is assembled identically and oByteReady remains 1 throughout COLLECT.
- Reset mid-sample: reset after 7 bytes, then iStart and 12 fresh bytes. The first write carries index 0 and only the fresh bytes. Also check that iStart during COLLECT is ignored.
